ex_stage_sequencer: RTL and testbench

Owns the ID/EX control register of the RV32I core and sequences the 32-bit control word from decode into execute. Inserts load-use bubbles, holds EX for a parameterised number of cycles on multi-cycle operations, and squashes the instruction entering EX on a taken branch or jump. Its registered `control_out` is the control word the EX/MEM datapath consumes and the monitor samples.

---
 rtl/ex_seq_pkg.sv | 18 +
 rtl/load_use_detect.sv | 24 ++
 rtl/ex_stage_sequencer.sv | 124 ++++++++++++
 tb/tb_ex_stage_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ex_seq_pkg.sv
// Shared constants and types for the ID/EX control sequencer.
// Control-word bit positions, FSM state encoding and multi-cycle counter width.
package ex_seq_pkg;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_MULTICYCLE = 4;

  localparam int MC_CNT_W = 4;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the instruction in ID.
// x0 never produces a hazard since it is never really written.
module load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  output logic       lu
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign w_rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

  assign lu = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid
              && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/ex_stage_sequencer.sv
// ID/EX control register with load-use bubble insertion, multi-cycle EX hold and branch squash.
// Stalls are combinational from state and current inputs; the ID/EX register is the only output state.
module ex_stage_sequencer
  import ex_seq_pkg::*;
#(
  parameter int MC_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_control,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_flush,
  output logic [31:0] control_out,
  output logic [4:0]  ex_rd,
  output logic        ex_valid,
  output logic        stall_if,
  output logic        stall_id
);

  localparam logic [MC_CNT_W-1:0] MC_RELOAD = MC_CNT_W'(MC_CYCLES - 2);

  state_t              r_state;
  logic [MC_CNT_W-1:0] r_cnt;
  logic [31:0]         r_ctrl;
  logic [4:0]          r_rd;
  logic                r_vld;

  state_t              w_state_nxt;
  logic [MC_CNT_W-1:0] w_cnt_nxt;
  logic [31:0]         w_ctrl_nxt;
  logic [4:0]          w_rd_nxt;
  logic                w_vld_nxt;
  logic                w_stall;
  logic                w_lu;

  load_use_detect u_lu (
    .ex_valid    (r_vld),
    .ex_mem_read (r_ctrl[CTRL_MEM_READ]),
    .ex_rd       (r_rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .lu          (w_lu)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ctrl_nxt  = r_ctrl;
    w_rd_nxt    = r_rd;
    w_vld_nxt   = r_vld;
    w_stall     = 1'b0;
    case (r_state)
      RUN: begin
        if (ex_flush) begin
          w_ctrl_nxt = '0;
          w_rd_nxt   = '0;
          w_vld_nxt  = 1'b0;
        end else if (w_lu) begin
          w_ctrl_nxt = '0;
          w_rd_nxt   = '0;
          w_vld_nxt  = 1'b0;
          w_stall    = 1'b1;
        end else begin
          w_ctrl_nxt = id_valid ? id_control : '0;
          w_rd_nxt   = id_valid ? id_rd : '0;
          w_vld_nxt  = id_valid;
          // Only a fresh load arms BUSY; a MULTICYCLE word still resident after BUSY does not.
          if (id_valid && id_control[CTRL_MULTICYCLE]) begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = MC_RELOAD;
          end
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_ctrl  <= '0;
      r_rd    <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ctrl  <= w_ctrl_nxt;
      r_rd    <= w_rd_nxt;
      r_vld   <= w_vld_nxt;
    end
  end

  assign control_out = r_ctrl;
  assign ex_rd       = r_rd;
  assign ex_valid    = r_vld;
  assign stall_if    = w_stall;
  assign stall_id    = w_stall;

  a_no_flush_in_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_state == BUSY && ex_flush));

  a_stalls_match: assert property (@(posedge clk) stall_if == stall_id);

endmodule

// File: tb/tb_ex_stage_sequencer.sv
// Directed self-checking bench for ex_stage_sequencer (MC_CYCLES = 4).
module tb_ex_stage_sequencer;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_control;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        ex_flush;
  logic [31:0] control_out;
  logic [4:0]  ex_rd;
  logic        ex_valid;
  logic        stall_if;
  logic        stall_id;

  int n_chk;
  int n_err;

  ex_stage_sequencer #(.MC_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_control  (id_control),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_flush    (ex_flush),
    .control_out (control_out),
    .ex_rd       (ex_rd),
    .ex_valid    (ex_valid),
    .stall_if    (stall_if),
    .stall_id    (stall_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] c, input logic [4:0] rs1,
                        input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd);
    id_valid    = v;
    id_control  = c;
    id_rs1      = rs1;
    id_uses_rs1 = u1;
    id_rs2      = rs2;
    id_uses_rs2 = u2;
    id_rd       = rd;
  endtask

  task automatic chk_ex(input string tag, input logic [31:0] c, input logic [4:0] rd,
                        input logic v);
    chk({tag, "_ctrl"}, control_out, c);
    chk({tag, "_rd"}, {27'd0, ex_rd}, {27'd0, rd});
    chk({tag, "_vld"}, {31'd0, ex_valid}, {31'd0, v});
  endtask

  task automatic chk_stall(input string tag, input logic s);
    #1;
    chk({tag, "_stall_if"}, {31'd0, stall_if}, {31'd0, s});
    chk({tag, "_stall_id"}, {31'd0, stall_id}, {31'd0, s});
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    ex_flush = 1'b0;

    // Reset with random ID-side inputs
    rst_n = 1'b0;
    set_id(1'b1, $urandom, 5'($urandom), 1'b1, 5'($urandom), 1'b1, 5'($urandom));
    tick();
    chk_ex("rst", 32'h0, 5'd0, 1'b0);
    rst_n = 1'b1;
    set_id(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    chk_stall("rst", 1'b0);

    // Load-use on rs1: lw x5 then add using x5
    set_id(1'b1, 32'h0000_0003, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5);
    tick();
    chk_ex("lw_in_ex", 32'h0000_0003, 5'd5, 1'b1);
    set_id(1'b1, 32'h0000_0101, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6);
    chk_stall("lu", 1'b1);
    tick();
    chk_ex("lu_bubble", 32'h0, 5'd0, 1'b0);
    chk_stall("lu_after", 1'b0);
    tick();
    chk_ex("lu_dep", 32'h0000_0101, 5'd6, 1'b1);

    // Load-use via rs2 only (rs1 matches but unused)
    set_id(1'b1, 32'h0000_0003, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12);
    tick();
    set_id(1'b1, 32'h0000_0004, 5'd12, 1'b0, 5'd3, 1'b1, 5'd0);
    chk_stall("rs1_unused", 1'b0);
    set_id(1'b1, 32'h0000_0004, 5'd3, 1'b0, 5'd12, 1'b1, 5'd0);
    chk_stall("lu_rs2", 1'b1);
    tick();
    chk_ex("lu_rs2_bubble", 32'h0, 5'd0, 1'b0);
    tick();
    chk_ex("lu_rs2_dep", 32'h0000_0004, 5'd0, 1'b1);

    // x0 destination never hazards
    set_id(1'b1, 32'h0000_0003, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0);
    tick();
    chk_ex("lw_x0", 32'h0000_0003, 5'd0, 1'b1);
    set_id(1'b1, 32'h0000_0201, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7);
    chk_stall("x0", 1'b0);
    tick();
    chk_ex("x0_next", 32'h0000_0201, 5'd7, 1'b1);

    // Invalid ID loads zeros
    set_id(1'b0, 32'hFFFF_FFFF, 5'd0, 1'b0, 5'd0, 1'b0, 5'd31);
    tick();
    chk_ex("inv", 32'h0, 5'd0, 1'b0);

    // Multi-cycle op: held 4 cycles, stalls during first 3
    set_id(1'b1, 32'h0000_0011, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8);
    tick();
    set_id(1'b1, 32'h0000_0401, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9);
    for (int i = 0; i < 4; i++) begin
      chk_ex($sformatf("mc_hold%0d", i), 32'h0000_0011, 5'd8, 1'b1);
      chk_stall($sformatf("mc%0d", i), (i < 3));
      tick();
    end
    chk_ex("mc_next", 32'h0000_0401, 5'd9, 1'b1);
    set_id(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    chk_stall("mc_done", 1'b0);

    // Flush beats load-use
    set_id(1'b1, 32'h0000_0003, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5);
    tick();
    set_id(1'b1, 32'h0000_0101, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6);
    ex_flush = 1'b1;
    chk_stall("flush_lu", 1'b0);
    tick();
    ex_flush = 1'b0;
    chk_ex("flush", 32'h0, 5'd0, 1'b0);
    set_id(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);

    // Reset during the second BUSY cycle
    set_id(1'b1, 32'h0000_0011, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10);
    tick();
    set_id(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    chk_stall("busy1", 1'b1);
    tick();
    chk_stall("busy2", 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_ex("mid_rst", 32'h0, 5'd0, 1'b0);
    set_id(1'b1, 32'h0000_0801, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11);
    chk_stall("mid_rst", 1'b0);
    tick();
    chk_ex("post_rst", 32'h0000_0801, 5'd11, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
